// File: rtl/scan_display_mux.sv
// Time-multiplexed driver for common-anode seven-segment banks.
// Scans one digit per slot with anti-ghost blanking, per-digit enable and blink.
module scan_display_mux #(
    parameter int NDIG       = 4,
    parameter int DW         = 4,
    parameter int SCAN_DIV   = 128,
    parameter int BLANK_CYC  = 8,
    parameter int BLINK_BITS = 24,
    localparam int SW        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NDIG*DW-1:0] digits_in,
    input  logic [NDIG-1:0]    digit_en,
    input  logic [NDIG-1:0]    blink_en,
    output logic [DW-1:0]      dig_out,
    output logic [NDIG-1:0]    anode_n,
    output logic [SW-1:0]      digit_sel,
    output logic               blink_phase
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(NDIG - 1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [PW-1:0]         p;
    logic [PW-1:0]         p_nx;
    logic [SW-1:0]         sel_nx;
    logic [BLINK_BITS-1:0] bcnt;
    logic                  lit;
    logic                  lit_nx;
    logic [DW-1:0]         dig_nx;
    logic [NDIG-1:0]       anode_nx;
    logic                  wrap;
    logic                  drive_nx;
    logic                  latch;

    assign wrap        = (p == P_LAST);
    assign p_nx        = wrap ? '0 : p + PW'(1);
    assign sel_nx      = !wrap ? digit_sel :
                         (digit_sel == S_LAST) ? '0 : digit_sel + SW'(1);
    assign blink_phase = bcnt[BLINK_BITS-1];

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign drive_nx = 1'b1;
        end else begin : g_blank
            assign drive_nx = (p_nx >= PW'(BLANK_CYC));
        end
    endgenerate

    // Outputs are computed from next-state so they line up with p.
    always_comb begin
        state_nx = drive_nx ? DRIVE : BLANK;
        latch    = drive_nx &&
                   (state == BLANK || p_nx == PW'(BLANK_CYC));
        dig_nx   = dig_out;
        lit_nx   = lit;
        if (latch) begin
            dig_nx = digits_in[sel_nx*DW +: DW];
            lit_nx = digit_en[sel_nx] &
                     ~(blink_en[sel_nx] & blink_phase);
        end
        anode_nx = '1;
        if (drive_nx && lit_nx) begin
            anode_nx = ~(NDIG'(1) << sel_nx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            p         <= '0;
            digit_sel <= '0;
            bcnt      <= '0;
            lit       <= 1'b0;
            dig_out   <= '0;
            anode_n   <= '1;
        end else begin
            state     <= state_nx;
            p         <= p_nx;
            digit_sel <= sel_nx;
            bcnt      <= bcnt + BLINK_BITS'(1);
            lit       <= lit_nx;
            dig_out   <= dig_nx;
            anode_n   <= anode_nx;
        end
    end

endmodule

// File: tb/tb_scan_display_mux.sv
// Directed bench for scan_display_mux: scan order, enable, blink, tearing,
// async reset, and two parameter corners with always-on invariant checks.
module tb_scan_display_mux;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] digits;
    logic [3:0]  den;
    logic [3:0]  ben;
    logic [3:0]  dig;
    logic [3:0]  an;
    logic [1:0]  sel;
    logic        bph;

    logic [11:0] d3;
    logic [2:0]  en3;
    logic [2:0]  bl3;
    logic [3:0]  dig3;
    logic [2:0]  an3;
    logic [1:0]  sel3;
    logic        bph3;

    logic [23:0] d8;
    logic [7:0]  en8;
    logic [7:0]  bl8;
    logic [2:0]  dig8;
    logic [7:0]  an8;
    logic [2:0]  sel8;
    logic        bph8;

    int          vecs = 0;
    int          errs = 0;

    logic [3:0]  e_en;
    logic [3:0]  e_bl;
    bit          tear;

    int          run3;
    bit          first3;
    logic [2:0]  prev3;
    int          drv [4];

    always #5 clk = ~clk;

    scan_display_mux #(
        .NDIG(4), .DW(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_BITS(6)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .digits_in(digits), .digit_en(den),
        .blink_en(ben), .dig_out(dig), .anode_n(an), .digit_sel(sel),
        .blink_phase(bph)
    );

    scan_display_mux #(
        .NDIG(3), .DW(4), .SCAN_DIV(8), .BLANK_CYC(0), .BLINK_BITS(6)
    ) u_n3 (
        .clk(clk), .rst_n(rst_n), .digits_in(d3), .digit_en(en3),
        .blink_en(bl3), .dig_out(dig3), .anode_n(an3), .digit_sel(sel3),
        .blink_phase(bph3)
    );

    scan_display_mux #(
        .NDIG(8), .DW(3), .SCAN_DIV(12), .BLANK_CYC(2), .BLINK_BITS(6)
    ) u_n8 (
        .clk(clk), .rst_n(rst_n), .digits_in(d8), .digit_en(en8),
        .blink_en(bl8), .dig_out(dig8), .anode_n(an8), .digit_sel(sel8),
        .blink_phase(bph8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int dval(input int k);
        int s;
        s = k % 4;
        if (s == 0) return (tear && k > 0) ? 9 : 1;
        return s + 1;
    endfunction

    task automatic check_main(input int n);
        int         k;
        int         p;
        int         s;
        int         ed;
        bit         ph;
        bit         lit;
        logic [3:0] ea;
        k   = n / 8;
        p   = n % 8;
        s   = k % 4;
        ph  = ((k / 4) % 2) == 1;
        lit = e_en[s] && !(e_bl[s] && ph);
        ea  = (p >= 2 && lit) ? ~(4'b0001 << s) : 4'hF;
        if (p >= 2) ed = dval(k);
        else        ed = (k == 0) ? 0 : dval(k - 1);
        chk("anode", an, ea);
        chk("dig", dig, ed);
        chk("sel", sel, s);
        chk("blink", bph, (n / 32) % 2);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run3   = 0;
            first3 = 1'b1;
            prev3  = '1;
        end else begin
            chk("main one-hot", $countones(~an) <= 1, 1);
            chk("main sel range", sel < 4, 1);
            chk("n3 one-hot", $countones(~an3) <= 1, 1);
            chk("n3 sel range", sel3 < 3, 1);
            chk("n8 one-hot", $countones(~an8) <= 1, 1);
            chk("n8 sel range", sel8 < 8, 1);
            if (an3 != prev3) begin
                if (prev3 != 3'b111) begin
                    chk("n3 run", run3, first3 ? 7 : 8);
                    first3 = 1'b0;
                end
                run3  = 1;
                prev3 = an3;
            end else begin
                run3++;
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        digits = 16'h4321;
        den    = 4'hF;
        ben    = 4'h0;
        e_en   = 4'hF;
        e_bl   = 4'h0;
        tear   = 1'b0;
        d3     = 12'h321;
        en3    = 3'b111;
        bl3    = 3'b000;
        d8     = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        en8    = 8'hFF;
        bl8    = 8'hFF;

        @(negedge clk);
        chk("rst anode", an, 4'hF);
        chk("rst dig", dig, 0);
        chk("rst sel", sel, 0);
        chk("rst blink", bph, 0);
        chk("rst n3 anode", an3, 3'b111);
        chk("rst n8 anode", an8, 8'hFF);

        // Scan order plus blink toggling mid-slot on the 8-digit corner.
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 96; n++) begin
            if (n > 0) step();
            check_main(n);
            case (n)
                30: begin
                    chk("n8 pre-toggle anode", an8, 8'hFB);
                    chk("n8 pre-toggle dig", dig8, 2);
                end
                33: begin
                    chk("n8 mid-toggle anode", an8, 8'hFB);
                    chk("n8 mid-toggle phase", bph8, 1);
                end
                40: begin
                    chk("n8 blink-off anode", an8, 8'hFF);
                    chk("n8 blink-off dig", dig8, 3);
                end
                62: chk("n8 blink-off2 anode", an8, 8'hFF);
                74: begin
                    chk("n8 blink-on anode", an8, 8'hBF);
                    chk("n8 blink-on dig", dig8, 6);
                end
                default: ;
            endcase
        end

        // Enable, blink and tearing, ending in an async reset mid-slot.
        @(negedge clk);
        rst_n = 1'b0;
        den   = 4'b0011;
        ben   = 4'b0001;
        e_en  = 4'b0011;
        e_bl  = 4'b0001;
        for (int i = 0; i < 4; i++) drv[i] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n <= 85; n++) begin
            if (n > 0) step();
            if (n == 4) begin
                digits[3:0] = 4'd9;
                tear        = 1'b1;
            end
            check_main(n);
            if (n < 32 && an != 4'hF) drv[n / 8]++;
        end
        chk("slot0 driven", drv[0], 6);
        chk("slot1 driven", drv[1], 6);
        chk("slot2 driven", drv[2], 0);
        chk("slot3 driven", drv[3], 0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async anode", an, 4'hF);
        chk("async dig", dig, 0);
        chk("async sel", sel, 0);
        chk("async blink", bph, 0);
        chk("async n8 sel", sel8, 0);
        digits = 16'h4321;
        den    = 4'hF;
        ben    = 4'h0;
        e_en   = 4'hF;
        e_bl   = 4'h0;
        tear   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 1900; n++) begin
            if (n > 0) step();
            check_main(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/scan_display_mux.md
Name: scan_display_mux

Overview:
- Parametrised time-multiplexed driver for common-anode seven-segment banks (NDIG digits, DW-bit digit codes).
- Sits between the game/score logic and the segment decoder.
- Scans one digit per slot, with these per-slot features:
  - Programmable slot length.
  - Anti-ghost blanking interval at the start of each slot.
  - Per-digit enable (leading-zero or unused-digit suppression).
  - Per-digit blink with a programmable blink period.
- Drive values are latched per slot, so the displayed digit cannot tear mid-slot.

Parameters:
- NDIG, 4, number of digits/anodes (>=2).
- DW, 4, width of one digit code.
- SCAN_DIV, 128, clock cycles per digit slot (>BLANK_CYC, >=2).
- BLANK_CYC, 8, cycles at the start of each slot with all anodes off (0 = no blanking).
- BLINK_BITS, 24, width of the free-running blink counter. Blink phase = its MSB, so the period is 2^BLINK_BITS cycles at 50% duty.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- digits_in, input, NDIG*DW, digit codes; digit i = bits [i*DW +: DW]; digit 0 = LSD.
- digit_en, input, NDIG, 1 = digit i may light.
- blink_en, input, NDIG, 1 = digit i blanks while blink phase = 1.
- dig_out, output, DW, code of the currently driven digit (to the segment decoder).
- anode_n, output, NDIG, active-low anode drive; bit i = digit i.
- digit_sel, output, max(1,$clog2(NDIG)), index of the current slot.
- blink_phase, output, 1, current blink counter MSB (for ghost/shadow effects elsewhere).

Behaviour:
- Reset (async, rst_n=0):
  - Prescaler p=0, digit_sel=0, blink counter=0.
  - anode_n=all 1s, dig_out=0, blink_phase=0.
  - Outputs take these values immediately, not at the next edge.
- Prescaler:
  - p increments every clk and runs 0..SCAN_DIV-1.
  - At p=SCAN_DIV-1, p wraps to 0 and digit_sel advances.
  - digit_sel wraps NDIG-1 -> 0. For non-power-of-2 NDIG, indices >= NDIG are never reached.
- Slot phases, two states:
  - BLANK: p < BLANK_CYC. anode_n=all 1s.
  - DRIVE: BLANK_CYC <= p <= SCAN_DIV-1.
  - BLANK->DRIVE when p reaches BLANK_CYC. DRIVE->BLANK when p wraps.
  - If BLANK_CYC=0, BLANK is skipped, except that the first cycle after reset release is always blank.
- Slot latch, on the edge that enters DRIVE:
  - dig_out <= digits_in[digit_sel], lit <= digit_en[digit_sel] & ~(blink_en[digit_sel] & blink_phase).
  - These values are held for the rest of the slot. Input changes mid-slot have no effect until the next slot.
  - dig_out keeps its last value through the following BLANK.
- DRIVE output:
  - anode_n = ~(lit << digit_sel), i.e. only bit digit_sel low, and only if lit.
  - A disabled or blinked-off digit still consumes its full slot with anode_n=all 1s, so duty stays uniform for the other digits.
- Registering and timing:
  - All outputs are registered, computed from next-state, so they are valid in the same cycle as the p value they belong to.
  - No combinational path from inputs to outputs.
- Blink counter:
  - Free-running, BLINK_BITS wide, wraps at 2^BLINK_BITS.
  - Unaffected by the slot logic.
  - blink_phase is sampled only at the slot latch, so a blink toggle mid-slot takes effect at the next slot.
- Invariants:
  - At most one anode_n bit is low in any cycle.
  - Never any low anode while p < BLANK_CYC.
- Reset mid-slot: immediate return to the reset state. Scanning restarts at digit 0, p=0.

Test Plan (NDIG=4, DW=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_BITS=6 unless stated):
- Reset/scan order: digits_in=16'h4321, digit_en=4'hF, blink_en=0, release reset.
  - Response: anode_n=4'hF during p=0,1. Then 4'b1110 with dig_out=1 for p=2..7.
  - Then 2 blank cycles, then 4'b1101/dig_out=2, 4'b1011/3, 4'b0111/4.
  - Then the sequence repeats from digit 0. Each slot lasts 8 cycles.
- Digit enable: digit_en=4'b0011.
  - Response: slots 2 and 3 keep anode_n=4'hF for all 8 cycles.
  - Slots 0 and 1 keep exactly 6 driven cycles.
- Blink: blink_en=4'b0001.
  - Response: digit 0 lights only in slots latched while blink_phase=0. blink_phase toggles every 32 cycles.
  - Digits 1-3 are unaffected.
  - Also check a toggle that lands mid-slot: it takes effect only from the next slot.
- No tearing: change digits_in[3:0] from 1 to 9 at p=4 of slot 0.
  - Response: dig_out stays 1 until the slot ends.
  - The next digit-0 slot shows 9.
- Async reset mid-scan: assert rst_n=0 at p=5 of slot 2 (between clock edges).
  - Response: anode_n=4'hF, dig_out=0, digit_sel=0 immediately.
  - After release, scanning restarts at digit 0 with 2 blank cycles.
- Parameter corners: run 2000 cycles with an always-on checker.
  - Configurations: NDIG=3 with BLANK_CYC=0, and NDIG=8 with DW=3.
  - Checks: digit_sel never >= NDIG; at most one anode_n bit is low in any cycle.
  - With BLANK_CYC=0 (after the first cycle), each digit is driven for 8 consecutive cycles per slot.
